// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit ripple-carry slice, one nibble per clock.
// LSB nibble first, carry registered between nibbles, start/busy/done handshake.

module Full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [3:0]        fa_sum;
  logic              fa_cout;
  logic [WIDTH-1:0]  acc_shift;

  Full_adder_4bit u_fa (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Shift form (rather than a concatenation slice) keeps WIDTH=4 legal.
  assign acc_shift = (acc_q >> 4) | (WIDTH'(fa_sum) << (WIDTH - 4));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        acc_d   = acc_shift;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed table, multi-cycle corner cases,
// and randomized back-to-back operation against an A+B+Cin arithmetic model.

module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, Cin, busy, done, Cout;
  logic [15:0] A, B, Sum;
  logic        s4, ci4, busy4, done4, co4;
  logic [3:0]  a4, b4, sum4;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .Cin(ci4),
    .busy(busy4), .done(done4), .Sum(sum4), .Cout(co4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  // One op on the 16-bit instance; returns result, done latency, busy cycles, extra dones.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input bit interfere, output logic [15:0] s, output logic co,
                      output int lat, output int bcnt, output int xdone);
    @(negedge clk);
    start = 1'b1; A = a; B = b; Cin = ci;
    @(negedge clk);
    start = 1'b0; A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    lat = 1; bcnt = busy ? 1 : 0; xdone = 0;
    while (!done && lat < 20) begin
      if (interfere && lat == 1) begin
        start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
    end
    s = Sum; co = Cout;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) xdone++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                     output logic [3:0] s, output logic co, output int lat);
    @(negedge clk);
    s4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
    @(negedge clk);
    s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum4; co = co4;
    @(negedge clk);
  endtask

  logic [15:0] rs;
  logic        rc;
  logic [3:0]  rs4;
  logic        rc4;
  int          lat, bcnt, xd;
  logic [16:0] expq[$];
  logic [16:0] e17;
  logic [4:0]  e5;
  logic [15:0] last_sum;
  logic        last_cout;
  int          ops;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_sum4", 32'({co4, sum4}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, lat, bcnt, xd);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].co));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd5);
      chk($sformatf("vec%0d_xdone", i), 32'(xd), 32'd0);
    end

    // Second request while RUN must be dropped, not queued.
    op16(16'h00FF, 16'h0001, 1'b0, 1'b1, rs, rc, lat, bcnt, xd);
    chk("ign_sum", 32'(rs), 32'h0100);
    chk("ign_cout", 32'(rc), 32'd0);
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_busy", 32'(bcnt), 32'd5);
    chk("ign_xdone", 32'(xd), 32'd0);

    // Abort in the second RUN cycle.
    @(negedge clk);
    start = 1'b1; A = 16'h8888; B = 16'h8888; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) xd++;
    end
    chk("abort_nodone", 32'(xd), 32'd0);
    chk("abort_sum_hold", 32'({Cout, Sum}), 32'd0);
    op16(16'h0003, 16'h0004, 1'b0, 1'b0, rs, rc, lat, bcnt, xd);
    chk("post_abort_sum", 32'(rs), 32'h0007);
    chk("post_abort_lat", 32'(lat), 32'd5);

    op4(4'hF, 4'hF, 1'b1, rs4, rc4, lat);
    chk("w4_sum", 32'(rs4), 32'hF);
    chk("w4_cout", 32'(rc4), 32'd1);
    chk("w4_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      logic       rci;
      ra = 4'($urandom); rb = 4'($urandom); rci = 1'($urandom);
      e5 = 5'(ra) + 5'(rb) + 5'(rci);
      op4(ra, rb, rci, rs4, rc4, lat);
      chk("w4_rand", 32'({rc4, rs4}), 32'(e5));
      chk("w4_rand_lat", 32'(lat), 32'd2);
    end

    // Start held high: one accept every 6 cycles, results vs A+B+Cin.
    repeat (3) @(negedge clk);
    last_sum = Sum; last_cout = Cout;
    ops = 0;
    start = 1'b1;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    expq.push_back(17'(A) + 17'(B) + 17'(Cin));
    for (int k = 1; ops < 1000 && k < 7000; k++) begin
      @(negedge clk);
      chk("b2b_hs", 32'({busy, done}), 32'({(k % 6) != 0, (k % 6) == 5}));
      if (done) begin
        if (expq.size() == 0) begin
          chk("b2b_underflow", 32'd1, 32'd0);
        end else begin
          e17 = expq.pop_front();
          last_sum = e17[15:0]; last_cout = e17[16];
        end
        ops++;
      end
      chk("b2b_result", 32'({Cout, Sum}), 32'({last_cout, last_sum}));
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
      if ((k % 6) == 0) expq.push_back(17'(A) + 17'(B) + 17'(Cin));
    end
    start = 1'b0;
    chk("b2b_ops", 32'(ops), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
